// File: rtl/axi_mem_arbiter_if.sv
// AXI4 bundle (AW/W/B/AR/R) shared by the arbiter's master and slave ports.
interface axi_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Write address channel
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;

  // Write data channel
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  // Write response channel
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  // Read address channel
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  // Read data channel
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  // Side that issues transactions
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  // Side that services transactions
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Two-master AXI4 arbiter onto one memory port: round-robin AR/AW,
// in-order W steering via an AW-order FIFO, ID-MSB based R/B return,
// and relocation of s1 addresses into the core memory window.
module axi_mem_arbiter #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       S_ID_W     = 4,
  parameter int unsigned       WIN_BITS   = 28,
  parameter logic [ADDR_W-1:0] REMAP_BASE = 32'h1000_0000,
  parameter int unsigned       WQ_DEPTH   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  axi_if.slave                        s0,
  axi_if.slave                        s1,
  axi_if.master                       m,
  output logic [$clog2(WQ_DEPTH):0]   wq_level
);

  localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

  // s1 keeps its low window bits; the upper bits come from the relocation base
  function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] a);
    return {REMAP_BASE[ADDR_W-1:WIN_BITS], a[WIN_BITS-1:0]};
  endfunction

  // ---------------------------------------------------------------- AR
  arb_state_e ar_state_q;
  logic       ar_hold_src_q;
  logic       ar_last_q;
  logic       ar_win_c;
  logic       ar_sel_c;
  logic       ar_valid_c;
  logic       ar_fire_c;

  // AR winner: lone requester, else the one not granted last; frozen while held
  always_comb begin
    ar_win_c   = (s0.arvalid & s1.arvalid) ? ~ar_last_q : s1.arvalid;
    ar_sel_c   = (ar_state_q == ARB_HOLD) ? ar_hold_src_q : ar_win_c;
    ar_valid_c = ~reset & (ar_sel_c ? s1.arvalid : s0.arvalid);
    ar_fire_c  = ar_valid_c & m.arready;
  end

  // AR lock / round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      ar_state_q    <= ARB_IDLE;
      ar_hold_src_q <= 1'b0;
      ar_last_q     <= 1'b1;
    end else begin
      case (ar_state_q)
        ARB_IDLE: begin
          if (ar_fire_c) begin
            ar_last_q <= ar_sel_c;
          end else if (ar_valid_c) begin
            ar_state_q    <= ARB_HOLD;
            ar_hold_src_q <= ar_sel_c;
          end
        end
        ARB_HOLD: begin
          if (ar_fire_c) begin
            ar_state_q <= ARB_IDLE;
            ar_last_q  <= ar_hold_src_q;
          end
        end
        default: ar_state_q <= ARB_IDLE;
      endcase
    end
  end

  assign m.arvalid  = ar_valid_c;
  assign m.arid     = {ar_sel_c, (ar_sel_c ? s1.arid : s0.arid)};
  assign m.araddr   = ar_sel_c ? remap(s1.araddr) : s0.araddr;
  assign m.arlen    = ar_sel_c ? s1.arlen   : s0.arlen;
  assign m.arsize   = ar_sel_c ? s1.arsize  : s0.arsize;
  assign m.arburst  = ar_sel_c ? s1.arburst : s0.arburst;
  assign m.arlock   = ar_sel_c ? s1.arlock  : s0.arlock;
  assign m.arcache  = ar_sel_c ? s1.arcache : s0.arcache;
  assign m.arprot   = ar_sel_c ? s1.arprot  : s0.arprot;
  assign m.arqos    = ar_sel_c ? s1.arqos   : s0.arqos;
  assign s0.arready = ar_valid_c & ~ar_sel_c & m.arready;
  assign s1.arready = ar_valid_c &  ar_sel_c & m.arready;

  // ---------------------------------------------------------------- AW-order FIFO state
  logic [WQ_DEPTH-1:0] wq_src_q;
  logic [PTR_W-1:0]    wq_wr_q;
  logic [PTR_W-1:0]    wq_rd_q;
  logic [LVL_W-1:0]    wq_level_q;
  logic                wq_full_c;
  logic                wq_empty_c;
  logic                wq_head_c;

  // FIFO status is taken from registered state only, so a same-cycle pop never unblocks AW
  always_comb begin
    wq_full_c  = (wq_level_q == LVL_W'(WQ_DEPTH));
    wq_empty_c = (wq_level_q == '0);
    wq_head_c  = wq_src_q[wq_rd_q];
  end

  // ---------------------------------------------------------------- AW
  arb_state_e aw_state_q;
  logic       aw_hold_src_q;
  logic       aw_last_q;
  logic       aw_win_c;
  logic       aw_sel_c;
  logic       aw_valid_c;
  logic       aw_fire_c;

  // AW winner, same rule as AR, additionally blocked while the order FIFO is full
  always_comb begin
    aw_win_c   = (s0.awvalid & s1.awvalid) ? ~aw_last_q : s1.awvalid;
    aw_sel_c   = (aw_state_q == ARB_HOLD) ? aw_hold_src_q : aw_win_c;
    aw_valid_c = ~reset & ~wq_full_c & (aw_sel_c ? s1.awvalid : s0.awvalid);
    aw_fire_c  = aw_valid_c & m.awready;
  end

  // AW lock / round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      aw_state_q    <= ARB_IDLE;
      aw_hold_src_q <= 1'b0;
      aw_last_q     <= 1'b1;
    end else begin
      case (aw_state_q)
        ARB_IDLE: begin
          if (aw_fire_c) begin
            aw_last_q <= aw_sel_c;
          end else if (aw_valid_c) begin
            aw_state_q    <= ARB_HOLD;
            aw_hold_src_q <= aw_sel_c;
          end
        end
        ARB_HOLD: begin
          if (aw_fire_c) begin
            aw_state_q <= ARB_IDLE;
            aw_last_q  <= aw_hold_src_q;
          end
        end
        default: aw_state_q <= ARB_IDLE;
      endcase
    end
  end

  assign m.awvalid  = aw_valid_c;
  assign m.awid     = {aw_sel_c, (aw_sel_c ? s1.awid : s0.awid)};
  assign m.awaddr   = aw_sel_c ? remap(s1.awaddr) : s0.awaddr;
  assign m.awlen    = aw_sel_c ? s1.awlen   : s0.awlen;
  assign m.awsize   = aw_sel_c ? s1.awsize  : s0.awsize;
  assign m.awburst  = aw_sel_c ? s1.awburst : s0.awburst;
  assign m.awlock   = aw_sel_c ? s1.awlock  : s0.awlock;
  assign m.awcache  = aw_sel_c ? s1.awcache : s0.awcache;
  assign m.awprot   = aw_sel_c ? s1.awprot  : s0.awprot;
  assign m.awqos    = aw_sel_c ? s1.awqos   : s0.awqos;
  assign s0.awready = aw_valid_c & ~aw_sel_c & m.awready;
  assign s1.awready = aw_valid_c &  aw_sel_c & m.awready;

  // ---------------------------------------------------------------- W steering
  logic w_valid_c;
  logic w_pop_c;

  // The FIFO head owns the W channel until its last beat is accepted
  always_comb begin
    w_valid_c = ~reset & ~wq_empty_c & (wq_head_c ? s1.wvalid : s0.wvalid);
    w_pop_c   = w_valid_c & m.wready & m.wlast;
  end

  // AW-order FIFO: push source on AW handshake, pop on last W beat
  always_ff @(posedge clock) begin
    if (reset) begin
      wq_src_q   <= '0;
      wq_wr_q    <= '0;
      wq_rd_q    <= '0;
      wq_level_q <= '0;
    end else begin
      if (aw_fire_c) begin
        wq_src_q[wq_wr_q] <= aw_sel_c;
        wq_wr_q           <= wq_wr_q + PTR_W'(1);
      end
      if (w_pop_c) begin
        wq_rd_q <= wq_rd_q + PTR_W'(1);
      end
      case ({aw_fire_c, w_pop_c})
        2'b10:   wq_level_q <= wq_level_q + LVL_W'(1);
        2'b01:   wq_level_q <= wq_level_q - LVL_W'(1);
        default: wq_level_q <= wq_level_q;
      endcase
    end
  end

  assign wq_level  = wq_level_q;
  assign m.wvalid  = w_valid_c;
  assign m.wdata   = wq_head_c ? s1.wdata : s0.wdata;
  assign m.wstrb   = wq_head_c ? s1.wstrb : s0.wstrb;
  assign m.wlast   = wq_head_c ? s1.wlast : s0.wlast;
  assign s0.wready = ~reset & ~wq_empty_c & ~wq_head_c & m.wready;
  assign s1.wready = ~reset & ~wq_empty_c &  wq_head_c & m.wready;

  // ---------------------------------------------------------------- R/B return by ID MSB
  assign s0.rvalid = m.rvalid & ~m.rid[S_ID_W];
  assign s1.rvalid = m.rvalid &  m.rid[S_ID_W];
  assign s0.rid    = m.rid[S_ID_W-1:0];
  assign s1.rid    = m.rid[S_ID_W-1:0];
  assign s0.rdata  = m.rdata;
  assign s1.rdata  = m.rdata;
  assign s0.rresp  = m.rresp;
  assign s1.rresp  = m.rresp;
  assign s0.rlast  = m.rlast;
  assign s1.rlast  = m.rlast;
  assign m.rready  = m.rid[S_ID_W] ? s1.rready : s0.rready;

  assign s0.bvalid = m.bvalid & ~m.bid[S_ID_W];
  assign s1.bvalid = m.bvalid &  m.bid[S_ID_W];
  assign s0.bid    = m.bid[S_ID_W-1:0];
  assign s1.bid    = m.bid[S_ID_W-1:0];
  assign s0.bresp  = m.bresp;
  assign s1.bresp  = m.bresp;
  assign m.bready  = m.bid[S_ID_W] ? s1.bready : s0.bready;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Self-checking bench for axi_mem_arbiter: R/B routing vector table,
// directed multi-cycle sequences, and randomized AR traffic vs a reference model.
module tb_axi_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] wq_level;

  int checks = 0;
  int errors = 0;

  axi_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) s0_bus ();
  axi_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) s1_bus ();
  axi_if #(.ADDR_W(32), .DATA_W(64), .ID_W(5)) m_bus ();

  axi_mem_arbiter #(
    .ADDR_W(32), .DATA_W(64), .S_ID_W(4), .WIN_BITS(28),
    .REMAP_BASE(32'h1000_0000), .WQ_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .s0(s0_bus), .s1(s1_bus), .m(m_bus),
    .wq_level(wq_level)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    s0_bus.awid = '0; s0_bus.awaddr = '0; s0_bus.awlen = '0; s0_bus.awsize = '0;
    s0_bus.awburst = '0; s0_bus.awlock = '0; s0_bus.awcache = '0; s0_bus.awprot = '0;
    s0_bus.awqos = '0; s0_bus.awvalid = 1'b0;
    s0_bus.wdata = '0; s0_bus.wstrb = '0; s0_bus.wlast = 1'b0; s0_bus.wvalid = 1'b0;
    s0_bus.bready = 1'b0;
    s0_bus.arid = '0; s0_bus.araddr = '0; s0_bus.arlen = '0; s0_bus.arsize = '0;
    s0_bus.arburst = '0; s0_bus.arlock = '0; s0_bus.arcache = '0; s0_bus.arprot = '0;
    s0_bus.arqos = '0; s0_bus.arvalid = 1'b0; s0_bus.rready = 1'b0;
    s1_bus.awid = '0; s1_bus.awaddr = '0; s1_bus.awlen = '0; s1_bus.awsize = '0;
    s1_bus.awburst = '0; s1_bus.awlock = '0; s1_bus.awcache = '0; s1_bus.awprot = '0;
    s1_bus.awqos = '0; s1_bus.awvalid = 1'b0;
    s1_bus.wdata = '0; s1_bus.wstrb = '0; s1_bus.wlast = 1'b0; s1_bus.wvalid = 1'b0;
    s1_bus.bready = 1'b0;
    s1_bus.arid = '0; s1_bus.araddr = '0; s1_bus.arlen = '0; s1_bus.arsize = '0;
    s1_bus.arburst = '0; s1_bus.arlock = '0; s1_bus.arcache = '0; s1_bus.arprot = '0;
    s1_bus.arqos = '0; s1_bus.arvalid = 1'b0; s1_bus.rready = 1'b0;
    m_bus.awready = 1'b0; m_bus.wready = 1'b0; m_bus.arready = 1'b0;
    m_bus.bid = '0; m_bus.bresp = '0; m_bus.bvalid = 1'b0;
    m_bus.rid = '0; m_bus.rdata = '0; m_bus.rresp = '0; m_bus.rlast = 1'b0; m_bus.rvalid = 1'b0;
  endtask

  // R/B routing vectors: inputs then expected outputs
  typedef struct packed {
    logic       rvalid;
    logic [4:0] rid;
    logic       r0_ready;
    logic       r1_ready;
    logic       bvalid;
    logic [4:0] bid;
    logic       b0_ready;
    logic       b1_ready;
    logic       e_s0_rvalid;
    logic       e_s1_rvalid;
    logic [3:0] e_rid;
    logic       e_m_rready;
    logic       e_s0_bvalid;
    logic       e_s1_bvalid;
    logic [3:0] e_bid;
    logic       e_m_bready;
  } rb_vec_t;

  rb_vec_t vecs [6];

  // Random-phase model state
  logic [1:0]  rq_v;
  logic [31:0] rq_addr [2];
  logic [3:0]  rq_id   [2];
  logic [7:0]  rq_len  [2];
  int          busy;
  int          last_grant;
  logic [31:0] exp_addr;
  logic        rv, rr0, rr1;
  logic [4:0]  rid_r;

  initial begin
    vecs[0] = '{1'b1, 5'b1_0011, 1'b0, 1'b1, 1'b1, 5'b0_0111, 1'b1, 1'b0,
                1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'h7, 1'b1};
    vecs[1] = '{1'b1, 5'b1_0011, 1'b1, 1'b0, 1'b1, 5'b0_0111, 1'b0, 1'b1,
                1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0};
    vecs[2] = '{1'b1, 5'b0_1010, 1'b1, 1'b0, 1'b0, 5'b1_1111, 1'b0, 1'b1,
                1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1};
    vecs[3] = '{1'b0, 5'b1_0000, 1'b0, 1'b1, 1'b1, 5'b1_0101, 1'b1, 1'b0,
                1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0};
    vecs[4] = '{1'b1, 5'b0_1111, 1'b0, 1'b1, 1'b1, 5'b1_1000, 1'b0, 1'b1,
                1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 4'h8, 1'b1};
    vecs[5] = '{1'b0, 5'b0_0000, 1'b1, 1'b1, 1'b0, 5'b0_0001, 1'b0, 1'b0,
                1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0};

    // Reset: requests present but everything must stay quiet
    idle_inputs();
    reset = 1'b1;
    tick();
    s0_bus.arvalid = 1'b1; m_bus.arready = 1'b1; m_bus.wready = 1'b1;
    s1_bus.awvalid = 1'b1; m_bus.awready = 1'b1;
    @(negedge clock);
    chk("rst_m_arvalid", m_bus.arvalid, 1'b0);
    chk("rst_m_awvalid", m_bus.awvalid, 1'b0);
    chk("rst_m_wvalid",  m_bus.wvalid,  1'b0);
    chk("rst_s0_arready", s0_bus.arready, 1'b0);
    chk("rst_s1_awready", s1_bus.awready, 1'b0);
    chk("rst_wq_level", wq_level, 3'd0);
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();

    // Table: R/B return routing
    foreach (vecs[i]) begin
      m_bus.rvalid = vecs[i].rvalid; m_bus.rid = vecs[i].rid;
      m_bus.rdata = 64'hDEAD_0000_0000_0000 + 64'(i);
      s0_bus.rready = vecs[i].r0_ready; s1_bus.rready = vecs[i].r1_ready;
      m_bus.bvalid = vecs[i].bvalid; m_bus.bid = vecs[i].bid;
      s0_bus.bready = vecs[i].b0_ready; s1_bus.bready = vecs[i].b1_ready;
      #2;
      chk("vec_s0_rvalid", s0_bus.rvalid, vecs[i].e_s0_rvalid);
      chk("vec_s1_rvalid", s1_bus.rvalid, vecs[i].e_s1_rvalid);
      chk("vec_s1_rid",    s1_bus.rid,    vecs[i].e_rid);
      chk("vec_m_rready",  m_bus.rready,  vecs[i].e_m_rready);
      chk("vec_s0_bvalid", s0_bus.bvalid, vecs[i].e_s0_bvalid);
      chk("vec_s1_bvalid", s1_bus.bvalid, vecs[i].e_s1_bvalid);
      chk("vec_s0_bid",    s0_bus.bid,    vecs[i].e_bid);
      chk("vec_m_bready",  m_bus.bready,  vecs[i].e_m_bready);
      chk("vec_s0_rdata",  s0_bus.rdata,  64'hDEAD_0000_0000_0000 + 64'(i));
      chk("vec_s1_rdata",  s1_bus.rdata,  64'hDEAD_0000_0000_0000 + 64'(i));
    end
    idle_inputs();
    tick();

    // Same-cycle AR contention after reset: s0 first, then relocated s1
    s0_bus.arvalid = 1'b1; s0_bus.araddr = 32'h0000_1000; s0_bus.arid = 4'h2;
    s1_bus.arvalid = 1'b1; s1_bus.araddr = 32'h2345_6780; s1_bus.arid = 4'h5;
    m_bus.arready = 1'b1;
    @(negedge clock);
    chk("t1_c0_araddr", m_bus.araddr, 32'h0000_1000);
    chk("t1_c0_arid",   m_bus.arid,   5'h02);
    chk("t1_c0_s1_arready", s1_bus.arready, 1'b0);
    tick();
    s0_bus.arvalid = 1'b0;
    @(negedge clock);
    chk("t1_c1_araddr", m_bus.araddr, 32'h1345_6780);
    chk("t1_c1_arid",   m_bus.arid,   5'h15);
    chk("t1_c1_s1_arready", s1_bus.arready, 1'b1);
    tick();
    s1_bus.arvalid = 1'b0;
    // one s0 read so the pointer now favours s1
    s0_bus.arvalid = 1'b1; s0_bus.araddr = 32'h0000_0800; s0_bus.arid = 4'h0;
    tick();
    s0_bus.arvalid = 1'b0; m_bus.arready = 1'b0;

    // AR held by back-pressure: selection frozen although s1 is now favoured
    s0_bus.arvalid = 1'b1; s0_bus.araddr = 32'h0000_2000; s0_bus.arid = 4'h3;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        s1_bus.arvalid = 1'b1; s1_bus.araddr = 32'h0000_0040; s1_bus.arid = 4'h1;
      end
      if (c == 3) m_bus.arready = 1'b1;
      @(negedge clock);
      chk("t2_hold_arvalid", m_bus.arvalid, 1'b1);
      chk("t2_hold_araddr",  m_bus.araddr,  32'h0000_2000);
      chk("t2_hold_arid",    m_bus.arid,    5'h03);
      chk("t2_hold_s1_arready", s1_bus.arready, 1'b0);
      tick();
    end
    s0_bus.arvalid = 1'b0;
    @(negedge clock);
    chk("t2_after_arid",   m_bus.arid,   5'h11);
    chk("t2_after_araddr", m_bus.araddr, 32'h1000_0040);
    chk("t2_after_s1_arready", s1_bus.arready, 1'b1);
    tick();
    idle_inputs();

    // W ordering: s1 AW (2 beats) then s0 AW; s0 data waits behind s1
    s1_bus.awvalid = 1'b1; s1_bus.awaddr = 32'h3000_0100; s1_bus.awid = 4'h9; s1_bus.awlen = 8'd1;
    m_bus.awready = 1'b1; m_bus.wready = 1'b1;
    s0_bus.wvalid = 1'b1; s0_bus.wlast = 1'b1; s0_bus.wdata = 64'h0000_0000_5050_5050;
    @(negedge clock);
    chk("t3_aw_s1_awid",   m_bus.awid,   5'h19);
    chk("t3_aw_s1_awaddr", m_bus.awaddr, 32'h1000_0100);
    chk("t3_aw_s1_awlen",  m_bus.awlen,  8'd1);
    chk("t3_empty_s0_wready", s0_bus.wready, 1'b0);
    chk("t3_empty_m_wvalid",  m_bus.wvalid,  1'b0);
    tick();
    s1_bus.awvalid = 1'b0;
    s0_bus.awvalid = 1'b1; s0_bus.awaddr = 32'h0000_0200; s0_bus.awid = 4'h4; s0_bus.awlen = 8'd0;
    @(negedge clock);
    chk("t3_aw_s0_awready", s0_bus.awready, 1'b1);
    chk("t3_aw_s0_awlen",   m_bus.awlen,    8'd0);
    chk("t3_head_s1_m_wvalid", m_bus.wvalid, 1'b0);
    chk("t3_head_s1_s0_wready", s0_bus.wready, 1'b0);
    tick();
    s0_bus.awvalid = 1'b0;
    s1_bus.wvalid = 1'b1; s1_bus.wlast = 1'b0; s1_bus.wdata = 64'h1111_0000_0000_0001;
    @(negedge clock);
    chk("t3_level2", wq_level, 3'd2);
    chk("t3_b0_wdata", m_bus.wdata, 64'h1111_0000_0000_0001);
    chk("t3_b0_s1_wready", s1_bus.wready, 1'b1);
    chk("t3_b0_s0_wready", s0_bus.wready, 1'b0);
    tick();
    s1_bus.wlast = 1'b1; s1_bus.wdata = 64'h1111_0000_0000_0002;
    @(negedge clock);
    chk("t3_b1_wlast", m_bus.wlast, 1'b1);
    chk("t3_b1_wdata", m_bus.wdata, 64'h1111_0000_0000_0002);
    chk("t3_b1_s0_wready", s0_bus.wready, 1'b0);
    tick();
    s1_bus.wvalid = 1'b0; s1_bus.wlast = 1'b0;
    @(negedge clock);
    chk("t3_s0_level1", wq_level, 3'd1);
    chk("t3_s0_wdata",  m_bus.wdata, 64'h0000_0000_5050_5050);
    chk("t3_s0_wready", s0_bus.wready, 1'b1);
    chk("t3_s0_m_wvalid", m_bus.wvalid, 1'b1);
    tick();
    s0_bus.wvalid = 1'b0;
    @(negedge clock);
    chk("t3_drained", wq_level, 3'd0);
    tick();
    idle_inputs();

    // FIFO full: four AWs fill it, fifth waits for a pop
    s0_bus.awvalid = 1'b1; s0_bus.awaddr = 32'h0000_4000; m_bus.awready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("t4_fill_level", wq_level, 3'(c));
      chk("t4_fill_awready", s0_bus.awready, 1'b1);
      tick();
    end
    s0_bus.wvalid = 1'b1; s0_bus.wlast = 1'b1; m_bus.wready = 1'b1;
    @(negedge clock);
    chk("t4_full_level", wq_level, 3'd4);
    chk("t4_full_awready", s0_bus.awready, 1'b0);
    chk("t4_full_m_awvalid", m_bus.awvalid, 1'b0);
    chk("t4_full_wready", s0_bus.wready, 1'b1);
    tick();
    s0_bus.wvalid = 1'b0;
    @(negedge clock);
    chk("t4_after_pop_level", wq_level, 3'd3);
    chk("t4_after_pop_awready", s0_bus.awready, 1'b1);
    tick();
    s0_bus.awvalid = 1'b0;
    @(negedge clock);
    chk("t4_refill_level", wq_level, 3'd4);
    tick();
    s0_bus.wvalid = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    s0_bus.wvalid = 1'b0;
    @(negedge clock);
    chk("t4_drain_level", wq_level, 3'd0);
    tick();
    idle_inputs();

    // Reset mid-operation: two AWs queued, s1 AR held
    s0_bus.arvalid = 1'b1; m_bus.arready = 1'b1;
    s1_bus.awvalid = 1'b1; m_bus.awready = 1'b1;
    tick();
    s0_bus.arvalid = 1'b0; m_bus.arready = 1'b0;
    s1_bus.arvalid = 1'b1; s1_bus.arid = 4'h6;
    tick();
    s1_bus.awvalid = 1'b0;
    @(negedge clock);
    chk("t6_pre_level", wq_level, 3'd2);
    chk("t6_pre_arid",  m_bus.arid, 5'h16);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    @(negedge clock);
    chk("t6_rst_level",   wq_level, 3'd0);
    chk("t6_rst_arvalid", m_bus.arvalid, 1'b0);
    chk("t6_rst_awvalid", m_bus.awvalid, 1'b0);
    chk("t6_rst_wvalid",  m_bus.wvalid,  1'b0);
    tick();
    reset = 1'b0;
    s0_bus.arvalid = 1'b1; s0_bus.arid = 4'hA;
    s1_bus.arvalid = 1'b1; s1_bus.arid = 4'hB;
    m_bus.arready = 1'b1;
    @(negedge clock);
    chk("t6_post_arid", m_bus.arid, 5'h0A);
    tick();
    s0_bus.arvalid = 1'b0;
    @(negedge clock);
    chk("t6_post2_arid", m_bus.arid, 5'h1B);
    tick();
    idle_inputs();

    // Randomized AR + R traffic against a transaction-level model
    rq_v = 2'b00;
    busy = -1;
    last_grant = 1;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!rq_v[n] && $urandom_range(0, 2) != 0) begin
          rq_v[n]    = 1'b1;
          rq_addr[n] = $urandom;
          rq_id[n]   = 4'($urandom_range(0, 15));
          rq_len[n]  = 8'($urandom_range(0, 255));
        end
      end
      s0_bus.arvalid = rq_v[0]; s0_bus.araddr = rq_addr[0]; s0_bus.arid = rq_id[0]; s0_bus.arlen = rq_len[0];
      s1_bus.arvalid = rq_v[1]; s1_bus.araddr = rq_addr[1]; s1_bus.arid = rq_id[1]; s1_bus.arlen = rq_len[1];
      m_bus.arready = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1)); rid_r = 5'($urandom_range(0, 31));
      rr0 = 1'($urandom_range(0, 1)); rr1 = 1'($urandom_range(0, 1));
      m_bus.rvalid = rv; m_bus.rid = rid_r; s0_bus.rready = rr0; s1_bus.rready = rr1;
      @(negedge clock);
      if (busy < 0 && rq_v != 2'b00) begin
        if (rq_v == 2'b11) busy = 1 - last_grant;
        else busy = rq_v[1] ? 1 : 0;
      end
      chk("rnd_arvalid", m_bus.arvalid, busy >= 0);
      if (busy >= 0) begin
        exp_addr = (busy == 1) ? ((rq_addr[1] & 32'h0FFF_FFFF) | 32'h1000_0000) : rq_addr[0];
        chk("rnd_araddr", m_bus.araddr, exp_addr);
        chk("rnd_arid",   m_bus.arid,   {busy[0], rq_id[busy]});
        chk("rnd_arlen",  m_bus.arlen,  rq_len[busy]);
        chk("rnd_s0_arready", s0_bus.arready, (busy == 0) & m_bus.arready);
        chk("rnd_s1_arready", s1_bus.arready, (busy == 1) & m_bus.arready);
        if (m_bus.arready) begin
          last_grant = busy;
          rq_v[busy] = 1'b0;
          busy = -1;
        end
      end
      chk("rnd_s0_rvalid", s0_bus.rvalid, rv & (rid_r < 5'd16));
      chk("rnd_s1_rvalid", s1_bus.rvalid, rv & (rid_r >= 5'd16));
      chk("rnd_m_rready",  m_bus.rready,  (rid_r >= 5'd16) ? rr1 : rr0);
      tick();
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
